updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 97 +++++++++
 tb/tb_updown_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Prescaled up/down counter with terminal count, sticky overflow/underflow flags and a wrap pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to hold the count at its limit instead of wrapping.
module updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2**WIDTH) - 1,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             flag_clear,
    output logic [WIDTH-1:0] counter_out,
    output logic             overflow_out,
    output logic             underflow_out,
    output logic             wrap_pulse
);

    localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [PW-1:0]    prescale_q, prescale_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q  <= '0;
            prescale_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            prescale_q <= prescale_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wrap_q     <= wrap_d;
        end
    end

    always_comb begin
        counter_d  = counter_q;
        prescale_d = prescale_q;
        // Clear is applied first so a same-cycle event below re-sets its flag.
        ovf_d      = ovf_q & ~flag_clear;
        unf_d      = unf_q & ~flag_clear;
        wrap_d     = 1'b0;

        if (load) begin
            counter_d  = (load_value > MAX_C) ? MAX_C : load_value;
            prescale_d = '0;
        end else if (enable) begin
            if (prescale_q == PS_LAST) begin
                prescale_d = '0;
                if (up_down) begin
                    if (counter_q == MAX_C) begin
                        ovf_d  = 1'b1;
                        wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
                        counter_d = MAX_C;
`else
                        counter_d = '0;
`endif
                    end else begin
                        counter_d = counter_q + WIDTH'(1);
                    end
                end else begin
                    if (counter_q == '0) begin
                        unf_d  = 1'b1;
                        wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
                        counter_d = '0;
`else
                        counter_d = MAX_C;
`endif
                    end else begin
                        counter_d = counter_q - WIDTH'(1);
                    end
                end
            end else begin
                prescale_d = prescale_q + PW'(1);
            end
        end
    end

    assign counter_out   = counter_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;
    assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench: three counter configurations driven in parallel and compared
// every cycle against an integer reference model, plus directed scenario checks.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, up_down, load, flag_clear;
    logic [3:0] load_value;

    logic [3:0] cnt [3];
    logic       ovf [3];
    logic       unf [3];
    logic       wr  [3];

    int total = 0;
    int bad   = 0;

    // Reference model state per instance
    int m_max [3] = '{15, 9, 9};
    int m_ps  [3] = '{1, 1, 3};
    int m_cnt [3];
    int m_pre [3];
    int m_ovf [3];
    int m_unf [3];
    int m_wr  [3];

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .flag_clear(flag_clear), .counter_out(cnt[0]),
        .overflow_out(ovf[0]), .underflow_out(unf[0]), .wrap_pulse(wr[0])
    );

    updown_counter #(.WIDTH(4), .MAX_COUNT(9)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .flag_clear(flag_clear), .counter_out(cnt[1]),
        .overflow_out(ovf[1]), .underflow_out(unf[1]), .wrap_pulse(wr[1])
    );

    updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .flag_clear(flag_clear), .counter_out(cnt[2]),
        .overflow_out(ovf[2]), .underflow_out(unf[2]), .wrap_pulse(wr[2])
    );

    task automatic check(input string tag, input int act, input int exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_wr[i] = 0;
            end else begin
                m_wr[i] = 0;
                if (flag_clear) begin
                    m_ovf[i] = 0;
                    m_unf[i] = 0;
                end
                if (load) begin
                    m_cnt[i] = (int'(load_value) > m_max[i]) ? m_max[i] : int'(load_value);
                    m_pre[i] = 0;
                end else if (enable) begin
                    m_pre[i] = (m_pre[i] + 1) % m_ps[i];
                    if (m_pre[i] == 0) begin
                        if (up_down) begin
                            if (m_cnt[i] + 1 > m_max[i]) begin
                                m_ovf[i] = 1; m_wr[i] = 1;
                                m_cnt[i] = SAT ? m_max[i] : 0;
                            end else m_cnt[i] = m_cnt[i] + 1;
                        end else begin
                            if (m_cnt[i] - 1 < 0) begin
                                m_unf[i] = 1; m_wr[i] = 1;
                                m_cnt[i] = SAT ? 0 : m_max[i];
                            end else m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.count", i), int'(cnt[i]), m_cnt[i]);
            check($sformatf("u%0d.ovf", i), int'(ovf[i]), m_ovf[i]);
            check($sformatf("u%0d.unf", i), int'(unf[i]), m_unf[i]);
            check($sformatf("u%0d.wrap", i), int'(wr[i]), m_wr[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic en, input logic ud, input logic ld,
                         input logic [3:0] lv, input logic fc);
        reset = r; enable = en; up_down = ud; load = ld; load_value = lv; flag_clear = fc;
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_wr[i] = 0;
        end

        // Reset state
        drive(1, 0, 1, 0, 4'd0, 0);
        tick(); tick();
        check("reset_count", int'(cnt[0]), 0);

        // Default config counts up through terminal count
        drive(0, 1, 1, 0, 4'd0, 0);
        pulses = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (wr[0]) pulses++;
            if (n < 15) check("up_run", int'(cnt[0]), n + 1);
        end
        check("up16_count", int'(cnt[0]), SAT ? 15 : 0);
        check("up16_ovf", int'(ovf[0]), 1);
        drive(0, 0, 1, 0, 4'd0, 0);
        tick();
        if (wr[0]) pulses++;
        check("wrap_pulse_width", pulses, 1);

        // flag_clear alone clears flags, count untouched
        drive(0, 0, 1, 0, 4'd0, 1);
        tick();
        check("clear_ovf", int'(ovf[0]), 0);
        check("clear_keeps_count", int'(cnt[0]), SAT ? 15 : 0);

        // Down from 0 with MAX_COUNT=9
        drive(1, 0, 0, 0, 4'd0, 0); tick();
        drive(0, 1, 0, 0, 4'd0, 0); tick();
        check("down_from0", int'(cnt[1]), SAT ? 0 : 9);
        check("down_unf", int'(unf[1]), 1);

        // PRESCALE=3: nine enabled cycles give three steps
        drive(1, 0, 1, 0, 4'd0, 0); tick();
        drive(0, 1, 1, 0, 4'd0, 0);
        for (int n = 0; n < 9; n++) tick();
        check("ps3_nine", int'(cnt[2]), 3);

        // Enable gap: the step lands on the 3rd enabled cycle
        drive(1, 0, 1, 0, 4'd0, 0); tick();
        drive(0, 1, 1, 0, 4'd0, 0); tick(); tick();
        drive(0, 0, 1, 0, 4'd0, 0); tick(); tick();
        check("ps3_gap_hold", int'(cnt[2]), 0);
        drive(0, 1, 1, 0, 4'd0, 0); tick();
        check("ps3_gap_step", int'(cnt[2]), 1);

        // Load clamps to MAX_COUNT and wins over enable
        drive(0, 1, 1, 1, 4'd15, 0); tick();
        check("load_clamp", int'(cnt[1]), 9);
        check("load_noflag", int'(ovf[1]), 0);
        check("load_nopulse", int'(wr[1]), 0);
        check("load_default", int'(cnt[0]), 15);

        // Set wins over simultaneous clear, then clear alone
        drive(0, 1, 1, 0, 4'd0, 1); tick();
        check("set_wins", int'(ovf[1]), 1);
        drive(0, 0, 1, 0, 4'd0, 1); tick();
        check("clear_after", int'(ovf[1]), 0);

        // Reset mid-prescale discards progress
        drive(0, 0, 1, 1, 4'd7, 0); tick();
        drive(0, 1, 1, 0, 4'd0, 0); tick(); tick();
        check("pre_reset_cnt", int'(cnt[2]), 7);
        drive(1, 1, 1, 0, 4'd0, 0); tick();
        check("mid_reset_cnt", int'(cnt[2]), 0);
        drive(0, 1, 1, 0, 4'd0, 0); tick(); tick();
        check("post_reset_hold", int'(cnt[2]), 0);
        tick();
        check("post_reset_step", int'(cnt[2]), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom),
                  ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
